// File: rtl/ls_exec_unit.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module  : ls_exec_unit
// Purpose : load/store execute stage - AGEN, req/ack memory access, CDB write-back
// Rev     : 1.0  initial release
// =============================================================================
module ls_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [3:0]  rob_num_in,
  input  logic [5:0]  p_rd_in,
  input  logic        mem_ren_in,
  input  logic        mem_wen_in,
  input  logic [15:0] immed_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        recover,
  input  logic [3:0]  rob_num_rec,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        complete_out,
  input  logic        cdb_grant,
  output logic [5:0]  p_rd_compl,
  output logic        RegDest_compl,
  output logic [3:0]  rob_num_compl,
  output logic [31:0] wb_data,
  output logic        ls_stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        agen_valid_q, agen_valid_d;
  logic [3:0]  agen_rob_q;
  logic [5:0]  agen_prd_q;
  logic        agen_ren_q, agen_wen_q;
  logic [31:0] agen_addr_q, agen_wdata_q;

  logic [3:0]  mem_rob_q;
  logic [5:0]  mem_prd_q;
  logic        mem_ren_q, mem_wen_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [31:0] wb_data_q, wb_data_d;
  logic        killed_q, killed_d;

  logic        w_agen_kill, w_mem_kill, w_agen_live;
  logic        w_accept, w_xfer;
  logic [31:0] w_addr;

  assign w_agen_kill = recover && (rob_num_rec == agen_rob_q);
  assign w_mem_kill  = recover && (rob_num_rec == mem_rob_q);
  assign w_agen_live = agen_valid_q && !w_agen_kill;

  // AGEN frees on the same edge it hands off, so a grant in WB lets a new issue in.
  assign ls_stall = agen_valid_q &&
                    !((state_q == S_IDLE) || ((state_q == S_WB) && cdb_grant));

  assign w_accept = issue && !recover && !ls_stall && (mem_ren_in || mem_wen_in);
  assign w_addr   = rs_data + {{16{immed_in[15]}}, immed_in};

  always_comb begin
    state_d   = state_q;
    w_xfer    = 1'b0;
    killed_d  = killed_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (w_agen_live) begin
          w_xfer  = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        killed_d = killed_q || w_mem_kill;
        // A killed request stays on the bus until acknowledged; only the broadcast is suppressed.
        if (mem_ack) begin
          killed_d = 1'b0;
          if (killed_q || w_mem_kill) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_WB;
            wb_data_d = mem_ren_q ? mem_rdata : 32'd0;
          end
        end
      end
      S_WB: begin
        if (w_mem_kill) begin
          state_d = S_IDLE;
        end else if (cdb_grant) begin
          if (w_agen_live) begin
            w_xfer  = 1'b1;
            state_d = S_ACCESS;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    agen_valid_d = agen_valid_q;
    if (w_accept) begin
      agen_valid_d = 1'b1;
    end else if (w_xfer || w_agen_kill) begin
      agen_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      agen_valid_q <= 1'b0;
      agen_rob_q   <= 4'd0;
      agen_prd_q   <= 6'd0;
      agen_ren_q   <= 1'b0;
      agen_wen_q   <= 1'b0;
      agen_addr_q  <= 32'd0;
      agen_wdata_q <= 32'd0;
      mem_rob_q    <= 4'd0;
      mem_prd_q    <= 6'd0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      wb_data_q    <= 32'd0;
      killed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      agen_valid_q <= agen_valid_d;
      killed_q     <= killed_d;
      wb_data_q    <= wb_data_d;
      if (w_accept) begin
        agen_rob_q   <= rob_num_in;
        agen_prd_q   <= p_rd_in;
        agen_ren_q   <= mem_ren_in;
        agen_wen_q   <= mem_wen_in;
        agen_addr_q  <= w_addr;
        agen_wdata_q <= rt_data;
      end
      if (w_xfer) begin
        mem_rob_q   <= agen_rob_q;
        mem_prd_q   <= agen_prd_q;
        mem_ren_q   <= agen_ren_q;
        mem_wen_q   <= agen_wen_q;
        mem_addr_q  <= agen_addr_q;
        mem_wdata_q <= agen_wdata_q;
      end
    end
  end

  assign mem_req       = (state_q == S_ACCESS);
  assign mem_we        = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign complete_out  = (state_q == S_WB);
  assign p_rd_compl    = mem_prd_q;
  assign RegDest_compl = mem_ren_q;
  assign rob_num_compl = mem_rob_q;
  assign wb_data       = wb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_ls_exec_unit.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module  : tb_ls_exec_unit
// Purpose : scoreboarded memory/CDB responders driven by directed issue steps
// Rev     : 1.0  initial release
// =============================================================================
module tb_ls_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue;
  logic [3:0]  rob_num_in;
  logic [5:0]  p_rd_in;
  logic        mem_ren_in, mem_wen_in;
  logic [15:0] immed_in;
  logic [31:0] rs_data, rt_data;
  logic        recover;
  logic [3:0]  rob_num_rec;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        complete_out;
  logic        cdb_grant;
  logic [5:0]  p_rd_compl;
  logic        RegDest_compl;
  logic [3:0]  rob_num_compl;
  logic [31:0] wb_data;
  logic        ls_stall;

  typedef struct {
    logic [3:0]  rob;
    logic [5:0]  prd;
    logic        ren;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } op_t;

  op_t mem_q[$];
  op_t cdb_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int checks = 0, failures = 0, nbcast = 0, cyc = 0;
  int ack_delay = 0, grant_delay = 0;
  bit grant_en = 1'b1;

  ls_exec_unit dut (
    .clk(clk), .rst(rst), .issue(issue), .rob_num_in(rob_num_in), .p_rd_in(p_rd_in),
    .mem_ren_in(mem_ren_in), .mem_wen_in(mem_wen_in), .immed_in(immed_in),
    .rs_data(rs_data), .rt_data(rt_data), .recover(recover), .rob_num_rec(rob_num_rec),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .complete_out(complete_out),
    .cdb_grant(cdb_grant), .p_rd_compl(p_rd_compl), .RegDest_compl(RegDest_compl),
    .rob_num_compl(rob_num_compl), .wb_data(wb_data), .ls_stall(ls_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory and CDB responders; they act on the falling edge, before stimulus moves.
  int          acc_cnt = 0, wb_cnt = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic        prev_cout = 1'b0, prev_grant = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wb = 32'd0;
  logic [3:0]  prev_rob = 4'd0;
  op_t         me, ce;

  initial begin
    mem_ack = 1'b0; cdb_grant = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      cdb_grant = 1'b0;
      if (!rst) begin
        acc_cnt = 0; wb_cnt = 0; prev_req = 1'b0; prev_cout = 1'b0;
      end else begin
        if (mem_req) begin
          if (prev_req && !prev_ack) begin
            chk("req_addr_stable", mem_addr, prev_addr);
            chk("req_we_stable", 32'(mem_we), 32'(prev_we));
          end
          if (acc_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            acc_cnt   = 0;
            mem_rdata = rd_model(mem_addr);
            chk("req_expected", 32'(mem_q.size() != 0), 32'd1);
            if (mem_q.size() != 0) begin
              me = mem_q.pop_front();
              chk("req_addr", mem_addr, me.addr);
              chk("req_we", 32'(mem_we), 32'(me.we));
              if (me.we) chk("req_wdata", mem_wdata, me.wdata);
            end
          end else begin
            acc_cnt++;
          end
        end else begin
          acc_cnt = 0;
        end
        if (complete_out) begin
          if (prev_cout && !prev_grant) begin
            chk("cdb_rob_stable", 32'(rob_num_compl), 32'(prev_rob));
            chk("cdb_data_stable", wb_data, prev_wb);
          end
          if (grant_en && wb_cnt >= grant_delay) begin
            cdb_grant = 1'b1;
            wb_cnt    = 0;
            nbcast++;
            chk("cdb_expected", 32'(cdb_q.size() != 0), 32'd1);
            if (cdb_q.size() != 0) begin
              ce = cdb_q.pop_front();
              chk("cdb_rob", 32'(rob_num_compl), 32'(ce.rob));
              chk("cdb_regdest", 32'(RegDest_compl), 32'(ce.ren));
              chk("cdb_data", wb_data, ce.data);
              if (ce.ren) chk("cdb_prd", 32'(p_rd_compl), 32'(ce.prd));
            end
          end else begin
            wb_cnt++;
          end
        end else begin
          wb_cnt = 0;
        end
        prev_req = mem_req;  prev_ack = mem_ack;  prev_addr = mem_addr;  prev_we = mem_we;
        prev_cout = complete_out; prev_grant = cdb_grant; prev_rob = rob_num_compl; prev_wb = wb_data;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [3:0] rob, input logic [5:0] prd, input logic ren,
                          input logic wen, input logic [31:0] rs, input logic [15:0] imm,
                          input logic [31:0] rt);
    op_t o;
    int  n;
    n = 0;
    while (ls_stall && n < 60) begin
      tick();
      n++;
    end
    chk("issue_ready", 32'(ls_stall), 32'd0);
    issue = 1'b1; rob_num_in = rob; p_rd_in = prd; mem_ren_in = ren; mem_wen_in = wen;
    rs_data = rs; immed_in = imm; rt_data = rt;
    if (ren || wen) begin
      o.rob = rob; o.prd = prd; o.ren = ren; o.we = wen;
      o.addr  = rs + {{16{imm[15]}}, imm};
      o.wdata = rt;
      o.data  = ren ? rd_model(o.addr) : 32'd0;
      mem_q.push_back(o);
      cdb_q.push_back(o);
    end
    tick();
    issue = 1'b0; mem_ren_in = 1'b0; mem_wen_in = 1'b0;
  endtask

  task automatic drop_cdb(input logic [3:0] rob);
    for (int i = 0; i < cdb_q.size(); i++) begin
      if (cdb_q[i].rob == rob) begin
        cdb_q.delete(i);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(mem_q.size() == 0 && cdb_q.size() == 0 && !mem_req && !complete_out) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_mem_q", 32'(mem_q.size()), 32'd0);
    chk("drain_cdb_q", 32'(cdb_q.size()), 32'd0);
    chk("drain_quiet", 32'({mem_req, complete_out}), 32'd0);
  endtask

  int n0, b0, w;

  initial begin
    rst = 1'b0; issue = 1'b0; rob_num_in = '0; p_rd_in = '0; mem_ren_in = 1'b0;
    mem_wen_in = 1'b0; immed_in = '0; rs_data = '0; rt_data = '0; recover = 1'b0;
    rob_num_rec = '0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_complete", 32'(complete_out), 32'd0);
    chk("rst_stall", 32'(ls_stall), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_compl_tags", 32'({p_rd_compl, rob_num_compl, RegDest_compl, mem_we}), 32'd0);
    rst = 1'b1;
    tick();

    // Load, zero-wait memory, immediate grant.
    mem_model[32'h0000_00FC] = 32'hDEAD_BEEF;
    ack_delay = 0; grant_delay = 0; grant_en = 1'b1;
    n0 = cyc;
    issue_op(4'd3, 6'd12, 1'b1, 1'b0, 32'h100, 16'hFFFC, 32'd0);
    chk("ld_agen_no_req", 32'(mem_req), 32'd0);
    tick();
    chk("ld_req", 32'(mem_req), 32'd1);
    chk("ld_addr", mem_addr, 32'h0000_00FC);
    chk("ld_we", 32'(mem_we), 32'd0);
    tick();
    chk("ld_complete", 32'(complete_out), 32'd1);
    chk("ld_latency", 32'(cyc - n0), 32'd3);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_prd", 32'(p_rd_compl), 32'd12);
    chk("ld_regdest", 32'(RegDest_compl), 32'd1);
    tick();
    chk("ld_idle", 32'(complete_out), 32'd0);

    // Store.
    issue_op(4'd5, 6'd0, 1'b0, 1'b1, 32'h200, 16'h0010, 32'h0000_55AA);
    tick();
    chk("st_addr", mem_addr, 32'h0000_0210);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'h0000_55AA);
    tick();
    chk("st_complete", 32'(complete_out), 32'd1);
    chk("st_regdest", 32'(RegDest_compl), 32'd0);
    chk("st_rob", 32'(rob_num_compl), 32'd5);
    chk("st_wb_data", wb_data, 32'd0);
    wait_idle();

    // Back-pressure: slow memory, slow CDB, three issues in a row.
    ack_delay = 3; grant_delay = 2;
    b0 = nbcast;
    issue_op(4'd9, 6'd20, 1'b1, 1'b0, 32'h1000, 16'h0004, 32'd0);
    issue_op(4'd10, 6'd0, 1'b0, 1'b1, 32'h2000, 16'hFFF0, 32'h1234_5678);
    chk("bp_stall", 32'(ls_stall), 32'd1);
    issue_op(4'd11, 6'd21, 1'b1, 1'b0, 32'h3000, 16'h0008, 32'd0);
    wait_idle();
    chk("bp_bcast_count", 32'(nbcast - b0), 32'd3);

    // Recover a load in ACCESS; the younger load in AGEN survives.
    ack_delay = 4; grant_delay = 0;
    b0 = nbcast;
    issue_op(4'd7, 6'd30, 1'b1, 1'b0, 32'h400, 16'h0000, 32'd0);
    issue_op(4'd8, 6'd31, 1'b1, 1'b0, 32'h500, 16'h0000, 32'd0);
    chk("rec_req", 32'(mem_req), 32'd1);
    recover = 1'b1; rob_num_rec = 4'd7;
    drop_cdb(4'd7);
    tick();
    recover = 1'b0;
    chk("rec_req_held", 32'(mem_req), 32'd1);
    chk("rec_addr_held", mem_addr, 32'h0000_0400);
    wait_idle();
    chk("rec_bcast_count", 32'(nbcast - b0), 32'd1);

    // Recover in WB with grant withheld, then a bubble issue.
    ack_delay = 0; grant_en = 1'b0;
    issue_op(4'd2, 6'd40, 1'b1, 1'b0, 32'h600, 16'h0000, 32'd0);
    w = 0;
    while (!complete_out && w < 20) begin
      tick();
      w++;
    end
    chk("wb_seen", 32'(complete_out), 32'd1);
    tick();
    chk("wb_hold", 32'(complete_out), 32'd1);
    recover = 1'b1; rob_num_rec = 4'd2;
    drop_cdb(4'd2);
    tick();
    recover = 1'b0;
    grant_en = 1'b1;
    chk("wbrec_drop", 32'(complete_out), 32'd0);
    chk("wbrec_no_req", 32'(mem_req), 32'd0);
    issue_op(4'd6, 6'd0, 1'b0, 1'b0, 32'h700, 16'h0000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bubble_no_req", 32'({mem_req, complete_out}), 32'd0);
      tick();
    end
    chk("bubble_no_stall", 32'(ls_stall), 32'd0);

    // Asynchronous reset in the middle of an access.
    ack_delay = 20;
    issue_op(4'd4, 6'd1, 1'b1, 1'b0, 32'h800, 16'h0000, 32'd0);
    issue_op(4'd12, 6'd2, 1'b1, 1'b0, 32'h900, 16'h0000, 32'd0);
    chk("arst_pre_req", 32'(mem_req), 32'd1);
    chk("arst_pre_stall", 32'(ls_stall), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_complete", 32'(complete_out), 32'd0);
    chk("arst_stall", 32'(ls_stall), 32'd0);
    mem_q.delete();
    cdb_q.delete();
    tick(); tick();
    rst = 1'b1;
    tick();

    // Normal operation resumes after reset.
    ack_delay = 1; grant_delay = 1;
    b0 = nbcast;
    issue_op(4'd1, 6'd5, 1'b1, 1'b0, 32'hA00, 16'hFFFF, 32'd0);
    wait_idle();
    chk("post_rst_bcast", 32'(nbcast - b0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
